rps_match_fsmd_p: RTL and testbench

Parametrised rock-paper-scissors match controller (FSM plus datapath), the successor of the fixed two-player match block. One round per clock with moves from two players. The block checks each round, keeps score and decides the match result. Minimum round count, winning lead and counter width are parameters. It adds synchronous reset, live score outputs and a remaining-rounds output.

---
 rtl/rps_match_fsmd_p_if.sv | 24 ++
 rtl/rps_match_fsmd_p.sv | 119 +++++++++++
 tb/tb_rps_match_fsmd_p.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rps_match_fsmd_p_if.sv
// Move/config inputs and registered match status of the rock-paper-scissors controller.
interface rps_match_fsmd_p_if #(
   parameter int CW = 5
);
   logic          inizia;
   logic [1:0]    primo;
   logic [1:0]    secondo;
   logic [1:0]    manche;
   logic [1:0]    partita;
   logic          attiva;
   logic [CW-1:0] punti1;
   logic [CW-1:0] punti2;
   logic [CW-1:0] rimaste;

   modport master (
      output inizia, primo, secondo,
      input  manche, partita, attiva, punti1, punti2, rimaste
   );

   modport slave (
      input  inizia, primo, secondo,
      output manche, partita, attiva, punti1, punti2, rimaste
   );
endinterface

// File: rtl/rps_match_fsmd_p.sv
// Rock-paper-scissors match controller: one round per clock, score keeping,
// no-repeat rule for the last round winner, lead/budget based match decision.
module rps_match_fsmd_p #(
   parameter int MIN_MANCHE = 4,
   parameter int LEAD_WIN   = 2,
   parameter int CW         = 5
) (
   input logic               clk,
   input logic               rst,
   rps_match_fsmd_p_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_END} state_t;

   localparam logic [CW-1:0] ONE = CW'(1);

   state_t          state_q, state_d;
   logic [1:0]      manche_q, manche_d, partita_q, partita_d;
   logic [1:0]      fm1_q, fm1_d, fm2_q, fm2_d;
   logic [CW-1:0]   p1_q, p1_d, p2_q, p2_d, rim_q, rim_d, bud_q, bud_d;
   logic            valid, draw, p1_win;
   logic [CW-1:0]   played;
   logic signed [CW:0] diff, lead;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         manche_q  <= 2'b00;
         partita_q <= 2'b00;
         fm1_q     <= 2'b00;
         fm2_q     <= 2'b00;
         p1_q      <= '0;
         p2_q      <= '0;
         rim_q     <= '0;
         bud_q     <= '0;
      end else begin
         state_q   <= state_d;
         manche_q  <= manche_d;
         partita_q <= partita_d;
         fm1_q     <= fm1_d;
         fm2_q     <= fm2_d;
         p1_q      <= p1_d;
         p2_q      <= p2_d;
         rim_q     <= rim_d;
         bud_q     <= bud_d;
      end
   end

   // A move equal to a non-zero forbidden register is caught by the plain
   // inequality, since a legal move is never 00.
   assign valid  = (bus.primo != 2'b00) && (bus.secondo != 2'b00) &&
                   (bus.primo != fm1_q) && (bus.secondo != fm2_q);
   assign draw   = (bus.primo == bus.secondo);
   assign p1_win = (bus.primo == 2'b01 && bus.secondo == 2'b11) ||
                   (bus.primo == 2'b10 && bus.secondo == 2'b01) ||
                   (bus.primo == 2'b11 && bus.secondo == 2'b10);

   always_comb begin
      state_d   = state_q;
      manche_d  = manche_q;
      partita_d = partita_q;
      fm1_d     = fm1_q;
      fm2_d     = fm2_q;
      p1_d      = p1_q;
      p2_d      = p2_q;
      rim_d     = rim_q;
      bud_d     = bud_q;
      played    = '0;
      diff      = '0;
      lead      = '0;
      if (bus.inizia) begin
         bud_d     = CW'({bus.primo, bus.secondo}) + CW'(MIN_MANCHE);
         rim_d     = CW'({bus.primo, bus.secondo}) + CW'(MIN_MANCHE);
         p1_d      = '0;
         p2_d      = '0;
         fm1_d     = 2'b00;
         fm2_d     = 2'b00;
         manche_d  = 2'b00;
         partita_d = 2'b00;
         state_d   = S_PLAY;
      end else if (state_q != S_PLAY || !valid) begin
         manche_d = 2'b00;
      end else begin
         rim_d = rim_q - ONE;
         if (draw) begin
            manche_d = 2'b11;
            fm1_d    = 2'b00;
            fm2_d    = 2'b00;
         end else if (p1_win) begin
            manche_d = 2'b01;
            p1_d     = p1_q + ONE;
            fm1_d    = bus.primo;
            fm2_d    = 2'b00;
         end else begin
            manche_d = 2'b10;
            p2_d     = p2_q + ONE;
            fm2_d    = bus.secondo;
            fm1_d    = 2'b00;
         end
         // Decision is taken on the scores and budget as updated by this round.
         played = bud_q - rim_d;
         diff   = $signed({1'b0, p1_d}) - $signed({1'b0, p2_d});
         lead   = diff[CW] ? -diff : diff;
         if (played >= CW'(MIN_MANCHE) && lead >= (CW+1)'(LEAD_WIN)) begin
            partita_d = diff[CW] ? 2'b10 : 2'b01;
            state_d   = S_END;
         end else if (rim_d == '0) begin
            partita_d = (p1_d > p2_d) ? 2'b01 : (p2_d > p1_d) ? 2'b10 : 2'b11;
            state_d   = S_END;
         end
      end
   end

   assign bus.manche  = manche_q;
   assign bus.partita = partita_q;
   assign bus.attiva  = (state_q == S_PLAY);
   assign bus.punti1  = p1_q;
   assign bus.punti2  = p2_q;
   assign bus.rimaste = rim_q;
endmodule

// File: tb/tb_rps_match_fsmd_p.sv
// Directed vector table for the match controller followed by random rounds
// checked against an integer-level model of the game rules.
module tb_rps_match_fsmd_p;
   localparam int MIN  = 4;
   localparam int LEAD = 2;
   localparam int CW   = 5;
   localparam int OW   = 5 + 3*CW;

   typedef struct {
      logic       r, i;
      logic [1:0] p, s;
      int         m, pa, a, p1, p2, rim;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rps_match_fsmd_p_if #(.CW(CW)) bus ();
   rps_match_fsmd_p #(.MIN_MANCHE(MIN), .LEAD_WIN(LEAD), .CW(CW)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int   n_chk  = 0;
   int   n_pass = 0;
   vec_t tbl[$];

   // Model state: st 0 idle, 1 playing, 2 finished.
   int st, bud, rim, p1, p2, fm1, fm2, man, par;

   function automatic logic [OW-1:0] pack(int m, int pa, int a, int s1, int s2, int rm);
      return {2'(m), 2'(pa), 1'(a), CW'(s1), CW'(s2), CW'(rm)};
   endfunction

   function automatic logic [OW-1:0] dut_out();
      return {bus.manche, bus.partita, bus.attiva, bus.punti1, bus.punti2, bus.rimaste};
   endfunction

   function automatic void add(int r, int i, int p, int s, int m, int pa, int a,
                               int s1, int s2, int rm);
      vec_t v;
      v.r = 1'(r); v.i = 1'(i); v.p = 2'(p); v.s = 2'(s);
      v.m = m; v.pa = pa; v.a = a; v.p1 = s1; v.p2 = s2; v.rim = rm;
      tbl.push_back(v);
   endfunction

   task automatic check(string name, logic [OW-1:0] act, logic [OW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got {manche,partita,attiva,p1,p2,rim}=%h, want %h", name, act, exp);
   endtask

   task automatic apply(logic r, logic i, logic [1:0] p, logic [1:0] s);
      rst = r; bus.inizia = i; bus.primo = p; bus.secondo = s;
      @(posedge clk);
      #1;
   endtask

   function automatic bit beats(int a, int b);
      return ((a - b + 3) % 3) == 1;
   endfunction

   function automatic void model_step(logic r, logic i, int p, int s);
      int played, d;
      if (r) begin
         st = 0; bud = 0; rim = 0; p1 = 0; p2 = 0; fm1 = 0; fm2 = 0; man = 0; par = 0;
      end else if (i) begin
         bud = p*4 + s + MIN; rim = bud; p1 = 0; p2 = 0; fm1 = 0; fm2 = 0;
         man = 0; par = 0; st = 1;
      end else if (st != 1 || p == 0 || s == 0 || p == fm1 || s == fm2) begin
         man = 0;
      end else begin
         rim--;
         if (p == s) begin man = 3; fm1 = 0; fm2 = 0; end
         else if (beats(p, s)) begin man = 1; p1++; fm1 = p; fm2 = 0; end
         else begin man = 2; p2++; fm2 = s; fm1 = 0; end
         played = bud - rim;
         d = p1 - p2;
         if (played >= MIN && (d >= LEAD || -d >= LEAD)) begin
            par = (d > 0) ? 1 : 2; st = 2;
         end else if (rim == 0) begin
            par = (p1 > p2) ? 1 : (p2 > p1) ? 2 : 3; st = 2;
         end
      end
   endfunction

   initial begin
      bus.inizia = 1'b0; bus.primo = 2'b00; bus.secondo = 2'b00;
      // r i p s | manche partita attiva p1 p2 rimaste
      // Win by lead, then moves ignored after the end
      add(1,0,0,0, 0,0,0,0,0,0);
      add(0,1,0,0, 0,0,1,0,0,4);
      add(0,0,1,3, 1,0,1,1,0,3);
      add(0,0,2,1, 1,0,1,2,0,2);
      add(0,0,3,2, 1,0,1,3,0,1);
      add(0,0,1,3, 1,1,0,4,0,0);
      add(0,0,1,3, 0,1,0,4,0,0);
      // No-repeat rule and invalid moves
      add(0,1,0,0, 0,0,1,0,0,4);
      add(0,0,1,3, 1,0,1,1,0,3);
      add(0,0,1,2, 0,0,1,1,0,3);
      add(0,0,2,3, 2,0,1,1,1,2);
      add(0,0,0,1, 0,0,1,1,1,2);
      add(0,0,2,0, 0,0,1,1,1,2);
      add(0,0,1,3, 0,0,1,1,1,2);
      // Draw to budget
      add(0,1,0,1, 0,0,1,0,0,5);
      add(0,0,1,1, 3,0,1,0,0,4);
      add(0,0,2,2, 3,0,1,0,0,3);
      add(0,0,3,3, 3,0,1,0,0,2);
      add(0,0,1,1, 3,0,1,0,0,1);
      add(0,0,1,1, 3,3,0,0,0,0);
      // Narrow finish at budget exhaustion
      add(0,1,0,0, 0,0,1,0,0,4);
      add(0,0,1,3, 1,0,1,1,0,3);
      add(0,0,2,3, 2,0,1,1,1,2);
      add(0,0,3,2, 1,0,1,2,1,1);
      add(0,0,2,2, 3,1,0,2,1,0);
      // P2 lead of exactly LEAD_WIN at exactly MIN_MANCHE played, budget left
      add(0,1,0,1, 0,0,1,0,0,5);
      add(0,0,1,2, 2,0,1,0,1,4);
      add(0,0,3,3, 3,0,1,0,1,3);
      add(0,0,1,2, 2,0,1,0,2,2);
      add(0,0,3,3, 3,2,0,0,2,1);
      // Reset mid-match, reset beats inizia, max budget, abort by restart
      add(0,1,0,0, 0,0,1,0,0,4);
      add(0,0,1,3, 1,0,1,1,0,3);
      add(0,0,2,1, 1,0,1,2,0,2);
      add(1,0,1,3, 0,0,0,0,0,0);
      add(0,0,1,3, 0,0,0,0,0,0);
      add(1,1,3,3, 0,0,0,0,0,0);
      add(0,1,3,3, 0,0,1,0,0,19);
      add(0,0,1,3, 1,0,1,1,0,18);
      add(0,0,2,1, 1,0,1,2,0,17);
      add(0,0,3,2, 1,0,1,3,0,16);
      add(0,1,1,2, 0,0,1,0,0,10);

      foreach (tbl[k]) begin
         apply(tbl[k].r, tbl[k].i, tbl[k].p, tbl[k].s);
         check($sformatf("vec%0d", k), dut_out(),
               pack(tbl[k].m, tbl[k].pa, tbl[k].a, tbl[k].p1, tbl[k].p2, tbl[k].rim));
      end

      for (int k = 0; k < 3000; k++) begin
         logic r, i;
         logic [1:0] p, s;
         r = (k == 0) || ($urandom_range(0, 99) < 2);
         i = ($urandom_range(0, 99) < 6);
         p = 2'($urandom_range(0, 3));
         s = 2'($urandom_range(0, 3));
         model_step(r, i, int'(p), int'(s));
         apply(r, i, p, s);
         check($sformatf("rand%0d", k), dut_out(),
               pack(man, par, (st == 1) ? 1 : 0, p1, p2, rim));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
